mmio_bomb_responder: RTL

// Memory-mapped responder on the CPU data port. It services the load/store traffic that the

---
 rtl/mmio_bomb_responder.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mmio_bomb_responder.sv
// Memory-mapped game peripherals: countdown timer, strike counter, button capture, LEDs.
// Eight-word window at BASE_ADDR; registered read data, single-cycle store strobe.
module mmio_bomb_responder #(
  parameter logic [15:0] BASE_ADDR   = 16'hFF00,
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned NUM_BTN     = 4,
  parameter int unsigned MAX_STRIKES = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [15:0]        addr,
  input  logic [15:0]        wrData,
  input  logic               we,
  input  logic               rdEn,
  output logic [15:0]        rdData,
  output logic               hit,
  input  logic [NUM_BTN-1:0] buttons,
  output logic [15:0]        leds,
  output logic               tickPulse,
  output logic               exploded
);

  localparam int unsigned   PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PrescLast  = PW'(TICK_DIV - 1);
  localparam logic [2:0]    StrikeMax  = 3'(MAX_STRIKES);
  localparam logic [2:0]    OffCtrl    = 3'd0;
  localparam logic [2:0]    OffTimer   = 3'd1;
  localparam logic [2:0]    OffStatus  = 3'd2;
  localparam logic [2:0]    OffButtons = 3'd3;
  localparam logic [2:0]    OffLeds    = 3'd4;
  localparam logic [2:0]    OffStrike  = 3'd5;

  logic               run_q, run_d;
  logic [15:0]        timer_q, timer_d;
  logic               expired_q, expired_d;
  logic [2:0]         strikes_q, strikes_d;
  logic               pending_q, pending_d;
  logic [15:0]        leds_q, leds_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [15:0]        rd_data_q, rd_data_d;
  logic [NUM_BTN-1:0] btn_s1_q, btn_s2_q, btn_s3_q;

  logic [2:0]         off;
  logic               wr;
  logic               rd_clr;
  logic               tick;
  logic [NUM_BTN-1:0] rise;
  logic [15:0]        btn_ext;

  assign hit       = (addr[15:3] == BASE_ADDR[15:3]);
  assign off       = addr[2:0];
  assign wr        = we & hit;
  // A simultaneous store suppresses the read-clear side effect.
  assign rd_clr    = rdEn & hit & ~we & (off == OffButtons);
  assign tick      = run_q & (presc_q == PrescLast);
  assign rise      = btn_s2_q & ~btn_s3_q;
  assign tickPulse = tick;
  assign exploded  = expired_q | (strikes_q == StrikeMax);
  assign rdData    = rd_data_q;
  assign leds      = leds_q;

  always_comb begin
    btn_ext              = '0;
    btn_ext[NUM_BTN-1:0] = btn_s2_q;
  end

  always_comb begin
    presc_d   = presc_q;
    run_d     = run_q;
    timer_d   = timer_q;
    expired_d = expired_q;
    strikes_d = strikes_q;
    leds_d    = leds_q;
    pending_d = pending_q;

    if (run_q) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end

    if (tick && (timer_q != 16'd0)) begin
      timer_d = timer_q - 16'd1;
      if (timer_q == 16'd1) begin
        expired_d = 1'b1;
      end
    end

    // Stores are applied after the tick so a TIMER write overrides the decrement.
    if (wr) begin
      case (off)
        OffCtrl: begin
          run_d = wrData[0];
          if (wrData[1]) begin
            strikes_d = '0;
            expired_d = 1'b0;
          end
        end
        OffTimer: begin
          timer_d   = wrData;
          expired_d = (wrData == 16'd0);
        end
        OffLeds:   leds_d = wrData;
        OffStrike: begin
          if (strikes_q != StrikeMax) begin
            strikes_d = strikes_q + 3'd1;
          end
        end
        default: ;
      endcase
    end

    if (rd_clr) begin
      pending_d = 1'b0;
    end
    if (|rise) begin
      pending_d = 1'b1;
    end
  end

  always_comb begin
    rd_data_d = '0;
    if (hit) begin
      case (off)
        OffCtrl:    rd_data_d = {15'd0, run_q};
        OffTimer:   rd_data_d = timer_q;
        OffStatus:  rd_data_d = {11'd0, pending_q, strikes_q, expired_q};
        OffButtons: rd_data_d = btn_ext;
        OffLeds:    rd_data_d = leds_q;
        default:    rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      run_q     <= 1'b0;
      timer_q   <= '0;
      expired_q <= 1'b0;
      strikes_q <= '0;
      pending_q <= 1'b0;
      leds_q    <= '0;
      presc_q   <= '0;
      rd_data_q <= '0;
      btn_s1_q  <= '0;
      btn_s2_q  <= '0;
      btn_s3_q  <= '0;
    end else begin
      run_q     <= run_d;
      timer_q   <= timer_d;
      expired_q <= expired_d;
      strikes_q <= strikes_d;
      pending_q <= pending_d;
      leds_q    <= leds_d;
      presc_q   <= presc_d;
      rd_data_q <= rd_data_d;
      btn_s1_q  <= buttons;
      btn_s2_q  <= btn_s1_q;
      btn_s3_q  <= btn_s2_q;
    end
  end

endmodule
